// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM state, transaction owner
// and the latched bus request.
package mem_bus_arbiter_pkg;
  localparam int XLEN     = 64;
  localparam int STREAK_W = 4;

  localparam logic [2:0] IF_SIZE = 3'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_e;
  typedef enum logic [1:0] {NONE, OWN_IF, OWN_LS} arb_owner_e;

  typedef struct packed {
    logic              wen;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN/8-1:0] wstrb;
    logic [2:0]        size;
  } bus_req_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and bus-side signals of the arbiter; master is the arbiter's
// own view, slave is the surrounding pipeline/bridge view.
interface mem_bus_arbiter_if #(
  parameter int CPU_WIDTH = 64
);
  logic                   i_flush;
  logic                   i_if_req;
  logic [CPU_WIDTH-1:0]   i_if_addr;
  logic                   o_if_gnt;
  logic                   o_if_rvalid;
  logic [CPU_WIDTH-1:0]   o_if_rdata;
  logic                   i_ls_req;
  logic                   i_ls_wen;
  logic [CPU_WIDTH-1:0]   i_ls_addr;
  logic [CPU_WIDTH-1:0]   i_ls_wdata;
  logic [CPU_WIDTH/8-1:0] i_ls_wstrb;
  logic [2:0]             i_ls_size;
  logic                   o_ls_gnt;
  logic                   o_ls_rvalid;
  logic [CPU_WIDTH-1:0]   o_ls_rdata;
  logic                   o_bus_req;
  logic                   o_bus_wen;
  logic [CPU_WIDTH-1:0]   o_bus_addr;
  logic [CPU_WIDTH-1:0]   o_bus_wdata;
  logic [CPU_WIDTH/8-1:0] o_bus_wstrb;
  logic [2:0]             o_bus_size;
  logic                   i_bus_ack;
  logic                   i_bus_done;
  logic [CPU_WIDTH-1:0]   i_bus_rdata;
  logic                   o_busy;

  modport master (
    input  i_flush, i_if_req, i_if_addr,
    input  i_ls_req, i_ls_wen, i_ls_addr, i_ls_wdata, i_ls_wstrb, i_ls_size,
    input  i_bus_ack, i_bus_done, i_bus_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    output o_bus_req, o_bus_wen, o_bus_addr, o_bus_wdata, o_bus_wstrb, o_bus_size,
    output o_busy
  );

  modport slave (
    output i_flush, i_if_req, i_if_addr,
    output i_ls_req, i_ls_wen, i_ls_addr, i_ls_wdata, i_ls_wstrb, i_ls_size,
    output i_bus_ack, i_bus_done, i_bus_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    input  o_bus_req, o_bus_wen, o_bus_addr, o_bus_wdata, o_bus_wstrb, o_bus_size,
    input  o_busy
  );
endinterface

// File: rtl/mem_bus_arbiter_prio_sel.sv
// Winner pick between IF and LSU: LSU first, unless IF has waited through
// MAX_LSU_STREAK LSU grants. A flush makes IF ineligible this cycle.
module arb_prio_sel #(
  parameter int MAX_LSU_STREAK = 4,
  parameter int STREAK_W       = 4
) (
  input  logic                if_req,
  input  logic                ls_req,
  input  logic                flush,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_if,
  output logic                grant_ls
);
  logic if_eligible;
  logic streak_full;

  assign if_eligible = if_req && !flush;
  assign streak_full = (streak == STREAK_W'(MAX_LSU_STREAK));
  assign grant_if    = if_eligible && (!ls_req || streak_full);
  assign grant_ls    = ls_req && !grant_if;
endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing the memory bus between instruction
// fetch and the load/store unit; flushed IF responses are dropped.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int CPU_WIDTH      = XLEN,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  mem_bus_arbiter_if.master  bus
);
  arb_state_e          state_reg, state_next;
  arb_owner_e          owner_reg, owner_next;
  logic                kill_reg, kill_next;
  bus_req_t            req_reg, req_next;
  logic [STREAK_W-1:0] streak_reg, streak_next;

  logic sel_if, sel_ls;
  logic grant_if, grant_ls;
  logic in_idle;
  logic if_rvalid, ls_rvalid;

  arb_prio_sel #(
    .MAX_LSU_STREAK (MAX_LSU_STREAK),
    .STREAK_W       (STREAK_W)
  ) u_prio_sel (
    .if_req   (bus.i_if_req),
    .ls_req   (bus.i_ls_req),
    .flush    (bus.i_flush),
    .streak   (streak_reg),
    .grant_if (sel_if),
    .grant_ls (sel_ls)
  );

  assign in_idle  = (state_reg == IDLE);
  assign grant_if = in_idle && sel_if;
  assign grant_ls = in_idle && sel_ls;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      owner_reg  <= NONE;
      kill_reg   <= 1'b0;
      req_reg    <= '0;
      streak_reg <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      kill_reg   <= kill_next;
      req_reg    <= req_next;
      streak_reg <= streak_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    req_next    = req_reg;
    streak_next = streak_reg;

    case (state_reg)
      IDLE: begin
        if (grant_if) begin
          state_next = REQ;
          owner_next = OWN_IF;
          req_next   = '{wen: 1'b0, addr: bus.i_if_addr, wdata: '0,
                         wstrb: '0, size: IF_SIZE};
        end else if (grant_ls) begin
          state_next = REQ;
          owner_next = OWN_LS;
          req_next   = '{wen: bus.i_ls_wen, addr: bus.i_ls_addr,
                         wdata: bus.i_ls_wdata, wstrb: bus.i_ls_wstrb,
                         size: bus.i_ls_size};
        end
      end
      REQ: begin
        if (bus.i_bus_ack) begin
          state_next = bus.i_bus_done ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (bus.i_bus_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next == IDLE) begin
      owner_next = NONE;
    end

    // The bridge cannot abort, so a flushed fetch runs to completion and
    // only its response is suppressed.
    kill_next = kill_reg;
    if (!in_idle && owner_reg == OWN_IF && bus.i_flush) begin
      kill_next = 1'b1;
    end
    if (state_next == IDLE) begin
      kill_next = 1'b0;
    end

    // Saturating at the limit keeps a flush-blocked IF from being starved.
    if (!bus.i_if_req || grant_if) begin
      streak_next = '0;
    end else if (grant_ls && streak_reg != STREAK_W'(MAX_LSU_STREAK)) begin
      streak_next = streak_reg + STREAK_W'(1);
    end
  end

  always_comb begin
    if_rvalid = bus.i_bus_done && !in_idle && owner_reg == OWN_IF &&
                !(kill_reg || bus.i_flush);
    ls_rvalid = bus.i_bus_done && !in_idle && owner_reg == OWN_LS;

    bus.o_if_gnt    = grant_if;
    bus.o_ls_gnt    = grant_ls;
    bus.o_if_rvalid = if_rvalid;
    bus.o_ls_rvalid = ls_rvalid;
    bus.o_if_rdata  = if_rvalid ? bus.i_bus_rdata : '0;
    bus.o_ls_rdata  = ls_rvalid ? bus.i_bus_rdata : '0;

    bus.o_bus_req   = (state_reg == REQ);
    bus.o_bus_wen   = req_reg.wen;
    bus.o_bus_addr  = req_reg.addr[CPU_WIDTH-1:0];
    bus.o_bus_wdata = req_reg.wdata[CPU_WIDTH-1:0];
    bus.o_bus_wstrb = req_reg.wstrb[CPU_WIDTH/8-1:0];
    bus.o_bus_size  = req_reg.size;
    bus.o_busy      = !in_idle;
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a
// transaction-level model of grant priority, streak and flush rules.
module tb_mem_bus_arbiter;
  localparam int W          = 64;
  localparam int MAX_STREAK = 4;

  typedef enum int {W_NONE, W_IF, W_LS} who_e;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.CPU_WIDTH(W)) bif ();

  mem_bus_arbiter #(
    .CPU_WIDTH      (W),
    .MAX_LSU_STREAK (MAX_STREAK)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bif)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Model state: streak of LSU wins while IF waits, plus the expected latched request.
  int             streak_m = 0;
  who_e           e_owner  = W_NONE;
  logic           e_wen    = 1'b0;
  logic [W-1:0]   e_addr   = '0;
  logic [W-1:0]   e_wdata  = '0;
  logic [W/8-1:0] e_wstrb  = '0;
  logic [2:0]     e_size   = '0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic who_e pick(input bit ifr, input bit lsr, input bit fl);
    bit if_ok;
    if_ok = ifr && !fl;
    if (if_ok && lsr) return (streak_m == MAX_STREAK) ? W_IF : W_LS;
    if (if_ok) return W_IF;
    if (lsr) return W_LS;
    return W_NONE;
  endfunction

  task automatic set_if(input logic [W-1:0] addr);
    bif.i_if_req  = 1'b1;
    bif.i_if_addr = addr;
  endtask

  task automatic set_ls(input logic wen, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                        input logic [W/8-1:0] wstrb, input logic [2:0] size);
    bif.i_ls_req   = 1'b1;
    bif.i_ls_wen   = wen;
    bif.i_ls_addr  = addr;
    bif.i_ls_wdata = wdata;
    bif.i_ls_wstrb = wstrb;
    bif.i_ls_size  = size;
  endtask

  task automatic drop(input who_e won);
    if (won == W_IF) bif.i_if_req = 1'b0;
    if (won == W_LS) bif.i_ls_req = 1'b0;
  endtask

  task automatic idle_cycle();
    bif.i_if_req = 1'b0;
    bif.i_ls_req = 1'b0;
    tick();
    streak_m = 0;
  endtask

  // Called in an IDLE cycle with requests already driven.
  task automatic grant_step(input bit fl, output who_e won);
    bif.i_flush = fl;
    #1;
    won = pick(bif.i_if_req, bif.i_ls_req, fl);
    chk1("busy_idle", bif.o_busy, 1'b0);
    chk1("if_gnt", bif.o_if_gnt, won == W_IF);
    chk1("ls_gnt", bif.o_ls_gnt, won == W_LS);
    chk1("if_rvalid_idle", bif.o_if_rvalid, 1'b0);
    chk1("ls_rvalid_idle", bif.o_ls_rvalid, 1'b0);
    if (!bif.i_if_req || won == W_IF) streak_m = 0;
    else if (won == W_LS && streak_m < MAX_STREAK) streak_m++;
    if (won == W_IF) begin
      e_wen = 1'b0; e_addr = bif.i_if_addr; e_wstrb = '0; e_size = 3'd3;
    end else if (won == W_LS) begin
      e_wen = bif.i_ls_wen; e_addr = bif.i_ls_addr; e_wdata = bif.i_ls_wdata;
      e_wstrb = bif.i_ls_wstrb; e_size = bif.i_ls_size;
    end
    e_owner = won;
    tick();
    bif.i_flush    = 1'b0;
    bif.i_bus_ack  = 1'b0;
    bif.i_bus_done = 1'b0;
  endtask

  // Bridge side of one granted transaction; cycle 0 is the first REQ cycle.
  task automatic serve(input int ack_dly, input int done_dly, input logic [W-1:0] rd,
                       input int flush_at);
    int total;
    bit killed;
    bit exp_rv;
    total  = ack_dly + done_dly;
    killed = 0;
    for (int c = 0; c <= total; c++) begin
      bif.i_bus_ack   = (c == ack_dly);
      bif.i_bus_done  = (c == total);
      bif.i_bus_rdata = (c == total) ? rd : {$urandom, $urandom};
      bif.i_flush     = (c == flush_at);
      if (c == flush_at && e_owner == W_IF) killed = 1;
      #1;
      chk1("bus_req", bif.o_bus_req, c <= ack_dly);
      if (c <= ack_dly) begin
        chkw("bus_addr", bif.o_bus_addr, e_addr);
        chkw("bus_ctl", W'({bif.o_bus_wen, bif.o_bus_wstrb, bif.o_bus_size}),
             W'({e_wen, e_wstrb, e_size}));
        if (e_owner == W_LS) chkw("bus_wdata", bif.o_bus_wdata, e_wdata);
      end
      chk1("busy", bif.o_busy, 1'b1);
      chk1("no_gnt_if", bif.o_if_gnt, 1'b0);
      chk1("no_gnt_ls", bif.o_ls_gnt, 1'b0);
      exp_rv = (c == total) && !killed;
      chk1("if_rvalid", bif.o_if_rvalid, exp_rv && e_owner == W_IF);
      chkw("if_rdata", bif.o_if_rdata, (exp_rv && e_owner == W_IF) ? rd : '0);
      chk1("ls_rvalid", bif.o_ls_rvalid, exp_rv && e_owner == W_LS);
      chkw("ls_rdata", bif.o_ls_rdata, (exp_rv && e_owner == W_LS) ? rd : '0);
      tick();
    end
    bif.i_bus_ack  = 1'b0;
    bif.i_bus_done = 1'b0;
    bif.i_flush    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_bus_req"}, bif.o_bus_req, 1'b0);
    chkw({tag, "_bus_addr"}, bif.o_bus_addr, '0);
    chkw({tag, "_bus_wdata"}, bif.o_bus_wdata, '0);
    chkw({tag, "_bus_ctl"}, W'({bif.o_bus_wen, bif.o_bus_wstrb, bif.o_bus_size}), '0);
    chk1({tag, "_busy"}, bif.o_busy, 1'b0);
    chk1({tag, "_gnts"}, bif.o_if_gnt | bif.o_ls_gnt, 1'b0);
    chk1({tag, "_rvalids"}, bif.o_if_rvalid | bif.o_ls_rvalid, 1'b0);
    chkw({tag, "_rdata"}, bif.o_if_rdata | bif.o_ls_rdata, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    who_e won;
    bit   exp_order [10];
    int   ad, dd, fa;

    bif.i_flush = 0; bif.i_if_req = 0; bif.i_if_addr = '0;
    bif.i_ls_req = 0; bif.i_ls_wen = 0; bif.i_ls_addr = '0; bif.i_ls_wdata = '0;
    bif.i_ls_wstrb = '0; bif.i_ls_size = '0;
    bif.i_bus_ack = 0; bif.i_bus_done = 0; bif.i_bus_rdata = '0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // IF-only fetch: ack in first REQ cycle, done two cycles later
    set_if(64'h8000_0000);
    grant_step(1'b0, won);
    chk1("t1_if_won", won == W_IF, 1'b1);
    drop(won);
    serve(0, 2, 64'h13, -1);
    chk1("t1_busy_after", bif.o_busy, 1'b0);
    $display("txn directed: IF fetch 0x80000000 rdata 0x13");
    idle_cycle();

    // Both held continuously, immediate ack+done: fairness pattern
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    set_if(64'h8000_0100);
    set_ls(1'b0, 64'h8000_2000, '0, 8'hFF, 3'd3);
    for (int i = 0; i < 10; i++) begin
      grant_step(1'b0, won);
      chk1("t2_order", won == W_IF, exp_order[i]);
      serve(0, 0, {$urandom, $urandom}, -1);
      $display("txn directed: fairness grant %0d to %s", i, (won == W_IF) ? "IF" : "LS");
    end
    idle_cycle();

    // LSU store with ack delayed three cycles
    set_ls(1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 3'd2);
    grant_step(1'b0, won);
    chk1("t3_ls_won", won == W_LS, 1'b1);
    drop(won);
    serve(3, 1, 64'h0, -1);
    $display("txn directed: LSU store 0x80001000 <= 0xdeadbeef");
    idle_cycle();

    // IF flushed while waiting: response dropped, next IF normal
    set_if(64'h8000_0040);
    grant_step(1'b0, won);
    drop(won);
    serve(0, 3, 64'h1234, 1);
    chk1("t4_idle_after_kill", bif.o_busy, 1'b0);
    set_if(64'h8000_0080);
    grant_step(1'b0, won);
    chk1("t4_if_regrant", won == W_IF, 1'b1);
    drop(won);
    serve(0, 0, 64'h55, -1);
    $display("txn directed: IF flushed in WAIT, then refetch");
    idle_cycle();

    // Flush in IDLE: blocks IF, LSU still eligible
    set_if(64'h8000_00C0);
    set_ls(1'b0, 64'h8000_3000, '0, 8'hFF, 3'd3);
    grant_step(1'b1, won);
    chk1("t5_flush_ls", won == W_LS, 1'b1);
    drop(won);
    serve(1, 0, 64'h77, -1);
    grant_step(1'b1, won);
    chk1("t5_flush_none", won == W_NONE, 1'b1);
    chk1("t5_no_busy", bif.o_busy, 1'b0);
    grant_step(1'b0, won);
    drop(won);
    serve(0, 1, 64'h99, -1);
    $display("txn directed: flush in IDLE with both and with IF only");
    idle_cycle();

    // Reset in WAIT, stray done afterwards
    set_if(64'h8000_0200);
    grant_step(1'b0, won);
    drop(won);
    bif.i_bus_ack = 1'b1;
    tick();
    bif.i_bus_ack = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    streak_m = 0;
    chk_all_zero("t6_after_reset");
    bif.i_bus_done  = 1'b1;
    bif.i_bus_rdata = 64'hABCD;
    #1;
    chk_all_zero("t6_stray_done");
    tick();
    bif.i_bus_done = 1'b0;
    chk1("t6_busy_after", bif.o_busy, 1'b0);
    $display("txn directed: reset in WAIT, stray done ignored");

    // Randomized traffic against the model
    for (int t = 0; t < 60; t++) begin
      if (!bif.i_if_req && ($urandom % 2 == 1))
        set_if({$urandom, $urandom} & ~64'h3);
      if (!bif.i_ls_req && ($urandom % 2 == 1))
        set_ls(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
               8'($urandom), 3'($urandom_range(3, 0)));
      if (!bif.i_if_req && !bif.i_ls_req) begin
        bif.i_bus_ack   = 1'($urandom);
        bif.i_bus_done  = 1'($urandom);
        bif.i_bus_rdata = {$urandom, $urandom};
      end
      grant_step(($urandom % 5) == 0, won);
      if (won == W_NONE) begin
        $display("txn %0d: no grant (streak %0d)", t, streak_m);
      end else begin
        drop(won);
        ad = int'($urandom_range(3, 0));
        dd = int'($urandom_range(3, 0));
        fa = ($urandom % 3 == 0) ? int'($urandom_range(ad + dd, 0)) : -1;
        $display("txn %0d: %s addr=%h wen=%0d ack_dly=%0d done_dly=%0d flush_at=%0d streak=%0d",
                 t, (won == W_IF) ? "IF" : "LS", e_addr, e_wen, ad, dd, fa, streak_m);
        serve(ad, dd, {$urandom, $urandom}, fa);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
